sram_port_arbiter: RTL and testbench

- Shares the single read/write port (port 0) of the 64-bit x 256-word byte-masked dual-port SRAM macro between two requesters.
- Requester A is the core-side data path; requester B is the hardware-debugger access path.
- Arbitration is round-robin with a bounded burst. The block registers SRAM commands, tracks in-flight accesses in a 2-stage tag pipeline and routes read data back to the issuing requester.
- Fully pipelined: one access per cycle; the read-only port 1 is not touched.

---
 rtl/sram_arb_pkg.sv | 30 +++
 rtl/sram_port_arbiter_if.sv | 29 ++
 rtl/sram_rr_grant.sv | 81 ++++++++
 rtl/sram_port_arbiter.sv | 112 +++++++++++
 tb/tb_sram_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM port-0 arbiter: requester ids,
// arbitration states and the in-flight access tag.
package sram_arb_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 64;
  localparam int NUM_WMASKS_DEF = DATA_W_DEF / 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    is_read;
  } tag_t;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// One requester's command/response channel into the SRAM port arbiter.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_WMASKS = NUM_WMASKS_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sram_rr_grant.sv
// Round-robin grant with bounded burst between requesters A and B.
//
// state | meaning
// IDLE  | no grant last cycle; ties go to the requester that is not rr_last
// OWN_A | A granted last cycle; keeps the port up to BURST grants while B waits
// OWN_B | B granted last cycle; keeps the port up to BURST grants while A waits
module sram_rr_grant
  import sram_arb_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  arb_state_e state, state_nxt;
  req_id_e    rr_last, rr_last_nxt;
  logic [3:0] count, count_nxt;

  always_comb begin
    a_grant     = 1'b0;
    b_grant     = 1'b0;
    state_nxt   = IDLE;
    count_nxt   = '0;
    rr_last_nxt = rr_last;

    case (state)
      IDLE: begin
        if (a_valid && b_valid) begin
          if (other_req(rr_last) == REQ_A) a_grant = 1'b1;
          else                             b_grant = 1'b1;
        end else if (a_valid) begin
          a_grant = 1'b1;
        end else if (b_valid) begin
          b_grant = 1'b1;
        end
      end
      OWN_A: begin
        if (a_valid && ((count < BURST_C) || !b_valid)) a_grant = 1'b1;
        else if (b_valid)                                b_grant = 1'b1;
      end
      OWN_B: begin
        if (b_valid && ((count < BURST_C) || !a_valid)) b_grant = 1'b1;
        else if (a_valid)                                a_grant = 1'b1;
      end
      default: ;
    endcase

    // A repeat grant to the current owner extends its run; any other grant restarts at 1.
    if (a_grant) begin
      state_nxt   = OWN_A;
      rr_last_nxt = REQ_A;
      if (state == OWN_A) count_nxt = (count == BURST_C) ? count : count + 4'd1;
      else                count_nxt = 4'd1;
    end else if (b_grant) begin
      state_nxt   = OWN_B;
      rr_last_nxt = REQ_B;
      if (state == OWN_B) count_nxt = (count == BURST_C) ? count : count + 4'd1;
      else                count_nxt = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      rr_last <= REQ_B;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      rr_last <= rr_last_nxt;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between requesters A and B: registered SRAM command,
// two-stage tag pipeline and read-data return to the issuing requester.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_WMASKS = NUM_WMASKS_DEF,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_arbiter_if.slave    a_if,
  sram_port_arbiter_if.slave    b_if,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_din,
  input  logic [DATA_W-1:0]     sram_dout,
  output logic                  busy
);

  logic gnt_a, gnt_b, gnt_any;

  logic                  cmd_we;
  logic [NUM_WMASKS-1:0] cmd_wmask;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;

  tag_t stage0, stage1;

  sram_rr_grant #(
    .BURST (BURST)
  ) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_if.req_valid),
    .b_valid (b_if.req_valid),
    .a_grant (gnt_a),
    .b_grant (gnt_b)
  );

  assign gnt_any      = gnt_a | gnt_b;
  assign a_if.req_ready = gnt_a;
  assign b_if.req_ready = gnt_b;

  always_comb begin
    cmd_we    = a_if.req_we;
    cmd_wmask = a_if.req_wmask;
    cmd_addr  = a_if.req_addr;
    cmd_wdata = a_if.req_wdata;
    if (gnt_b) begin
      cmd_we    = b_if.req_we;
      cmd_wmask = b_if.req_wmask;
      cmd_addr  = b_if.req_addr;
      cmd_wdata = b_if.req_wdata;
    end
  end

  // Idle cycles deselect the macro but leave addr/din/wmask parked to avoid toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else if (gnt_any) begin
      sram_csb   <= 1'b0;
      sram_web   <= ~cmd_we;
      sram_wmask <= cmd_we ? cmd_wmask : '0;
      sram_addr  <= cmd_addr;
      sram_din   <= cmd_we ? cmd_wdata : '0;
    end else begin
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage0 <= '0;
      stage1 <= '0;
    end else begin
      stage0.valid   <= gnt_any;
      stage0.id      <= gnt_b ? REQ_B : REQ_A;
      stage0.is_read <= ~cmd_we;
      stage1         <= stage0;
    end
  end

  assign busy = stage0.valid | stage1.valid;

  // sram_dout is valid for the access in stage1; rsp_data holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_if.rsp_valid <= 1'b0;
      a_if.rsp_data  <= '0;
      b_if.rsp_valid <= 1'b0;
      b_if.rsp_data  <= '0;
    end else begin
      a_if.rsp_valid <= stage1.valid && (stage1.id == REQ_A);
      b_if.rsp_valid <= stage1.valid && (stage1.id == REQ_B);
      if (stage1.valid && (stage1.id == REQ_A))
        a_if.rsp_data <= stage1.is_read ? sram_dout : '0;
      if (stage1.valid && (stage1.id == REQ_B))
        b_if.rsp_data <= stage1.is_read ? sram_dout : '0;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a run-length
// arbitration model, a golden memory and an SRAM macro behavioural model.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 64;
  localparam int NUM_WMASKS = 8;
  localparam int BURST      = 4;

  typedef struct {
    bit          v;
    bit          we;
    logic [7:0]  mask;
    logic [7:0]  addr;
    logic [63:0] data;
  } req_t;

  typedef struct {
    bit          v;
    bit          is_b;
    logic [63:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WMASKS(NUM_WMASKS)) a_if ();
  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WMASKS(NUM_WMASKS)) b_if ();

  logic                  sram_csb, sram_web, busy;
  logic [NUM_WMASKS-1:0] sram_wmask;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W-1:0]     sram_din, sram_dout;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WMASKS(NUM_WMASKS), .BURST(BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_if       (a_if),
    .b_if       (b_if),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .busy       (busy)
  );

  // Port-0 macro: samples on the clock edge, registered read data.
  bit [63:0] sram_mem [256];
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int i = 0; i < 8; i++)
          if (sram_wmask[i]) sram_mem[sram_addr][i*8 +: 8] <= sram_din[i*8 +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr];
      end
    end
  end

  // Reference state
  bit [63:0]   gold [256];
  exp_t        pipe [3];
  bit          g1, g2;
  req_t        pc;
  logic [63:0] last_a, last_b;
  int          m_last;   // 1 = A, 2 = B
  int          m_run;    // consecutive grants to m_last; 0 after an idle cycle
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic req_t idle_req();
    req_t r;
    r.v = 0; r.we = 0; r.mask = '0; r.addr = '0; r.data = '0;
    return r;
  endfunction

  function automatic req_t mk(input bit we, input logic [7:0] mask, input logic [7:0] addr,
                              input logic [63:0] data);
    req_t r;
    r.v = 1; r.we = we; r.mask = mask; r.addr = addr; r.data = data;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.v    = ($urandom_range(0, 9) < 7);
    r.we   = 1'($urandom_range(0, 1));
    r.mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    r.addr = 8'($urandom_range(0, 15));
    r.data = {$urandom, $urandom};
    return r;
  endfunction

  function automatic int exp_grant(input bit av, input bit bv);
    int other;
    other = (m_last == 1) ? 2 : 1;
    if (!av && !bv) return 0;
    if (av && !bv)  return 1;
    if (!av)        return 2;
    if (m_run == 0) return other;
    if (m_run < BURST) return m_last;
    return other;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pipe[i].v = 0; pipe[i].is_b = 0; pipe[i].d = '0;
    end
    g1 = 0; g2 = 0;
    pc = idle_req();
    last_a = '0; last_b = '0;
    m_last = 2; m_run = 0;
  endtask

  task automatic drive(input req_t ra, input req_t rb);
    a_if.req_valid = ra.v; a_if.req_we = ra.we; a_if.req_wmask = ra.mask;
    a_if.req_addr  = ra.addr; a_if.req_wdata = ra.data;
    b_if.req_valid = rb.v; b_if.req_we = rb.we; b_if.req_wmask = rb.mask;
    b_if.req_addr  = rb.addr; b_if.req_wdata = rb.data;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_csb",     sram_csb, 1);
    check_eq("rst_web",     sram_web, 1);
    check_eq("rst_wmask",   sram_wmask, 0);
    check_eq("rst_addr",    sram_addr, 0);
    check_eq("rst_din",     sram_din, 0);
    check_eq("rst_a_rspv",  a_if.rsp_valid, 0);
    check_eq("rst_b_rspv",  b_if.rsp_valid, 0);
    check_eq("rst_a_rspd",  a_if.rsp_data, 0);
    check_eq("rst_b_rspd",  b_if.rsp_data, 0);
    check_eq("rst_busy",    busy, 0);
  endtask

  // One cycle: drive after the rising edge, check and advance the model on the falling edge.
  task automatic cyc(input req_t ra, input req_t rb);
    int   g;
    req_t gr;
    exp_t e;
    @(posedge clk);
    #1;
    drive(ra, rb);
    @(negedge clk);

    check_eq("a_rsp_valid", a_if.rsp_valid, pipe[0].v && !pipe[0].is_b);
    check_eq("b_rsp_valid", b_if.rsp_valid, pipe[0].v && pipe[0].is_b);
    if (pipe[0].v) begin
      if (pipe[0].is_b) last_b = pipe[0].d;
      else              last_a = pipe[0].d;
    end
    check_eq("a_rsp_data", a_if.rsp_data, last_a);
    check_eq("b_rsp_data", b_if.rsp_data, last_b);
    check_eq("busy", busy, g1 | g2);
    check_eq("sram_csb", sram_csb, !pc.v);
    check_eq("sram_web", sram_web, !(pc.v && pc.we));
    if (pc.v) begin
      check_eq("sram_addr", sram_addr, pc.addr);
      check_eq("sram_wmask", sram_wmask, pc.we ? pc.mask : 8'h00);
      check_eq("sram_din", sram_din, pc.we ? pc.data : 64'h0);
    end

    g = exp_grant(ra.v, rb.v);
    check_eq("a_req_ready", a_if.req_ready, g == 1);
    check_eq("b_req_ready", b_if.req_ready, g == 2);
    check_eq("both_ready", a_if.req_ready & b_if.req_ready, 0);

    pipe[0] = pipe[1];
    pipe[1] = pipe[2];
    e.v = 0; e.is_b = 0; e.d = '0;
    gr = idle_req();
    if (g != 0) begin
      gr = (g == 1) ? ra : rb;
      e.v = 1;
      e.is_b = (g == 2);
      if (gr.we) begin
        for (int i = 0; i < 8; i++)
          if (gr.mask[i]) gold[gr.addr][i*8 +: 8] = gr.data[i*8 +: 8];
        e.d = '0;
      end else begin
        e.d = gold[gr.addr];
      end
    end
    pipe[2] = e;
    g2 = g1;
    g1 = (g != 0);
    pc = gr;

    if (g == 0) begin
      m_run = 0;
    end else if (g == m_last) begin
      m_run = (m_run >= BURST) ? BURST : m_run + 1;
    end else begin
      m_last = g;
      m_run = 1;
    end
  endtask

  initial begin
    model_reset();
    drive(idle_req(), idle_req());
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // Single requester write then read-back
    cyc(mk(1, 8'hFF, 8'h10, 64'h1122334455667788), idle_req());
    cyc(mk(0, 8'h00, 8'h10, 64'h0), idle_req());
    repeat (3) cyc(idle_req(), idle_req());
    check_eq("rd_0x10", a_if.rsp_data, 64'h1122334455667788);

    // Byte mask over zero contents
    cyc(mk(1, 8'h0F, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF), idle_req());
    cyc(mk(0, 8'h00, 8'h20, 64'h0), idle_req());
    repeat (3) cyc(idle_req(), idle_req());
    check_eq("rd_0x20", a_if.rsp_data, 64'h0000_0000_FFFF_FFFF);

    // Tie from IDLE with bounded bursts
    repeat (12) cyc(mk(0, 8'h00, 8'h10, 64'h0), mk(0, 8'h00, 8'h20, 64'h0));
    repeat (3) cyc(idle_req(), idle_req());

    // Back-to-back reads 0..3 after seeding
    for (int i = 0; i < 4; i++) cyc(mk(1, 8'hFF, 8'(i), {32'hA5A5_0000, 32'(i)}), idle_req());
    for (int i = 0; i < 4; i++) cyc(mk(0, 8'h00, 8'(i), 64'h0), idle_req());
    repeat (3) cyc(idle_req(), idle_req());

    // Owner drops while the other waits; B must get its own data
    cyc(mk(1, 8'hFF, 8'h30, 64'hDEAD_BEEF_0000_0001), mk(1, 8'hFF, 8'h31, 64'hCAFE_F00D_0000_0002));
    cyc(idle_req(), mk(0, 8'h00, 8'h31, 64'h0));
    cyc(idle_req(), mk(0, 8'h00, 8'h30, 64'h0));
    repeat (4) cyc(idle_req(), idle_req());

    // Read-after-write same address, back to back
    cyc(mk(1, 8'hF0, 8'h05, 64'h0123_4567_89AB_CDEF), idle_req());
    cyc(mk(0, 8'h00, 8'h05, 64'h0), idle_req());
    repeat (3) cyc(idle_req(), idle_req());

    // Reset with a read in flight: outputs clear at once, no late response
    cyc(mk(0, 8'h00, 8'h10, 64'h0), idle_req());
    @(posedge clk);
    #1;
    drive(idle_req(), idle_req());
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc(idle_req(), idle_req());

    // Randomized traffic
    for (int n = 0; n < 1500; n++) cyc(rand_req(), rand_req());
    repeat (4) cyc(idle_req(), idle_req());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
